// File: rtl/es_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// es_ctrl_pkg
//  Shared encodings for the expression-stack control path: decode command
//  codes, ESOp encodings seen by ex_stack, named push sources for the pushVal
//  mux, and the sequencer state enum.
//  No ports (package).
// -----------------------------------------------------------------------------
package es_ctrl_pkg;

   // Command codes arriving from decode.
   typedef enum logic [1:0] {
      CMD_NOP  = 2'd0,
      CMD_PUSH = 2'd1,
      CMD_POP  = 2'd2,
      CMD_DUP  = 2'd3
   } cmd_e;

   // Stack operation encodings driven to ex_stack.
   typedef enum logic [1:0] {
      ES_NOP  = 2'b00,
      ES_PUSH = 2'b01,
      ES_POP  = 2'b10,
      ES_DUP  = 2'b11
   } es_op_e;

   // Push sources 0..5 select constants; these two select the operand registers.
   localparam logic [2:0] SRC_A = 3'd6;
   localparam logic [2:0] SRC_B = 3'd7;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_EXEC  = 2'd2
   } state_e;

endpackage

// File: rtl/es_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// es_op_sequencer_if
//  Command handshake between decode (master) and the stack sequencer (slave).
//  Signals:
//   req_valid  master->slave  command present
//   req_ready  slave->master  sequencer idle; transfer when valid && ready
//   req_cmd    master->slave  2-bit command code (es_ctrl_pkg::cmd_e)
//   req_src    master->slave  3-bit push source for CMD_PUSH
// -----------------------------------------------------------------------------
interface es_op_sequencer_if;

   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_cmd;
   logic [2:0] req_src;

   modport master (
      output req_valid,
      output req_cmd,
      output req_src,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_cmd,
      input  req_src,
      output req_ready
   );

endinterface

// File: rtl/es_depth_counter.sv
// -----------------------------------------------------------------------------
// es_depth_counter
//  Logical depth of the expression stack. Clear has priority over inc/dec.
//  The sequencer never requests inc at full or dec at empty; doing so is a
//  protocol violation caught by assertion rather than silently saturated.
//  Ports:
//   clk, rst_n          clock, async active-low reset
//   inc, dec, clear     one-cycle update requests
//   depth [DW-1:0]      current depth
//   full, empty         depth==DEPTH, depth==0
// -----------------------------------------------------------------------------
module es_depth_counter #(
   parameter  int DEPTH = 16,
   localparam int DW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          dec,
   input  logic          clear,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth <= '0;
      end else if (clear) begin
         depth <= '0;
      end else if (inc) begin
         depth <= depth + DW'(1);
      end else if (dec) begin
         depth <= depth - DW'(1);
      end
   end

   assign full  = (depth == DW'(DEPTH));
   assign empty = (depth == '0);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(inc && !clear && full))
      else $error("depth counter incremented at full");
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(dec && !clear && empty))
      else $error("depth counter decremented at empty");

endmodule

// File: rtl/es_op_sequencer.sv
// -----------------------------------------------------------------------------
// es_op_sequencer
//  Control FSM for the expression stack and its push-source path. Takes one
//  command at a time from decode, screens it against the current depth, and
//  drives pushSrc / ESOp / ESAct with the timing ex_stack expects. A push
//  spends one SETUP cycle so the pushVal register can capture the mux output
//  selected by pushSrc before the stack write in EXEC.
//  Ports:
//   clk, reset          clock, async active-low reset
//   req                 command handshake (es_op_sequencer_if.slave)
//   flush               empty the stack (honoured only when idle)
//   clr_err             clear sticky error flags
//   pushSrc [2:0]       registered push-source select
//   ESOp [1:0]          stack operation, valid while ESAct=1
//   ESAct               one-cycle stack action strobe
//   done, err           completion pulse / rejected-command pulse
//   ovf_flag, unf_flag  sticky overflow / underflow flags
//   depth [DW-1:0]      logical depth; full, empty derived from it
// -----------------------------------------------------------------------------
module es_op_sequencer
   import es_ctrl_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int DW    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   es_op_sequencer_if.slave    req,
   input  logic                flush,
   input  logic                clr_err,
   output logic [2:0]          pushSrc,
   output logic [1:0]          ESOp,
   output logic                ESAct,
   output logic                done,
   output logic                err,
   output logic                ovf_flag,
   output logic                unf_flag,
   output logic [DW-1:0]       depth,
   output logic                full,
   output logic                empty
);

   state_e state;
   cmd_e   cmd;
   logic   accept;
   logic   reject_ovf;
   logic   reject_unf;
   logic   depth_inc;
   logic   depth_dec;
   logic   depth_clear;

   // Flush wins over a request, so the handshake is withheld while it is high.
   assign req.req_ready = (state == ST_IDLE) && !flush;
   assign accept        = req.req_valid && req.req_ready;
   assign cmd           = cmd_e'(req.req_cmd);

   // NOTE: every signal assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      reject_ovf = 1'b0;
      reject_unf = 1'b0;
      if (accept) begin
         unique case (cmd)
            CMD_PUSH: reject_ovf = full;
            CMD_POP:  reject_unf = empty;
            // Empty takes precedence: a DUP with nothing to copy is an underflow.
            CMD_DUP: begin
               reject_unf = empty;
               reject_ovf = full && !empty;
            end
            default: ;
         endcase
      end
   end

   // Depth moves on the edge that ends EXEC, keyed off the registered strobe.
   assign depth_inc   = ESAct && ((ESOp == ES_PUSH) || (ESOp == ES_DUP));
   assign depth_dec   = ESAct && (ESOp == ES_POP);
   assign depth_clear = flush && (state == ST_IDLE);

   es_depth_counter #(
      .DEPTH (DEPTH)
   ) u_depth (
      .clk   (clk),
      .rst_n (reset),
      .inc   (depth_inc),
      .dec   (depth_dec),
      .clear (depth_clear),
      .depth (depth),
      .full  (full),
      .empty (empty)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         pushSrc  <= '0;
         ESOp     <= ES_NOP;
         ESAct    <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         ovf_flag <= 1'b0;
         unf_flag <= 1'b0;
      end else begin
         // Pulses default low; only EXEC entry and completion raise them.
         ESAct <= 1'b0;
         ESOp  <= ES_NOP;
         done  <= 1'b0;
         err   <= 1'b0;

         // A new rejection in the same cycle as clr_err keeps its flag set.
         ovf_flag <= (ovf_flag && !clr_err) || reject_ovf;
         unf_flag <= (unf_flag && !clr_err) || reject_unf;

         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (reject_ovf || reject_unf) begin
                     done <= 1'b1;
                     err  <= 1'b1;
                  end else begin
                     unique case (cmd)
                        CMD_NOP: done <= 1'b1;
                        CMD_PUSH: begin
                           pushSrc <= req.req_src;
                           state   <= ST_SETUP;
                        end
                        CMD_POP: begin
                           ESAct <= 1'b1;
                           ESOp  <= ES_POP;
                           state <= ST_EXEC;
                        end
                        CMD_DUP: begin
                           ESAct <= 1'b1;
                           ESOp  <= ES_DUP;
                           state <= ST_EXEC;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            // pushVal captures the mux output selected by pushSrc at the end of SETUP.
            ST_SETUP: begin
               ESAct <= 1'b1;
               ESOp  <= ES_PUSH;
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_es_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_es_op_sequencer
//  Self-checking bench for es_op_sequencer (DEPTH=16). A command-level model
//  tracks depth, sticky flags and the last push source; each command's
//  latency, strobe count, stack op and error response are compared with it.
// -----------------------------------------------------------------------------
module tb_es_op_sequencer;

   localparam int DEPTH = 16;
   localparam int DW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          flush = 1'b0;
   logic          clr_err = 1'b0;
   logic [2:0]    pushSrc;
   logic [1:0]    ESOp;
   logic          ESAct;
   logic          done;
   logic          err;
   logic          ovf_flag;
   logic          unf_flag;
   logic [DW-1:0] depth;
   logic          full;
   logic          empty;

   es_op_sequencer_if req_if ();

   es_op_sequencer #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req_if.slave),
      .flush    (flush),
      .clr_err  (clr_err),
      .pushSrc  (pushSrc),
      .ESOp     (ESOp),
      .ESAct    (ESAct),
      .done     (done),
      .err      (err),
      .ovf_flag (ovf_flag),
      .unf_flag (unf_flag),
      .depth    (depth),
      .full     (full),
      .empty    (empty)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Command-level reference state.
   int       m_depth;
   bit       m_ovf;
   bit       m_unf;
   bit [2:0] m_psrc;

   // Drive one command at a negedge (sequencer must be idle) and observe until
   // done or the cycle budget runs out. Leaves the caller at the done negedge.
   task automatic run_cmd(input logic [1:0] cmd, input logic [2:0] src, input logic clr,
                          output int lat, output int acts, output logic [1:0] op,
                          output logic e, output logic [2:0] psrc1);
      lat = 0; acts = 0; op = 2'b00; e = 1'b0; psrc1 = 3'd0;
      req_if.req_valid = 1'b1;
      req_if.req_cmd   = cmd;
      req_if.req_src   = src;
      clr_err          = clr;
      @(posedge clk);
      #1;
      req_if.req_valid = 1'b0;
      clr_err          = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) psrc1 = pushSrc;
         if (ESAct === 1'b1) begin
            acts++;
            op = ESOp;
         end
         if (done === 1'b1) begin
            lat = c;
            e   = err;
            break;
         end
      end
   endtask

   // Run one command against the model and compare every observable.
   task automatic test_command(input string name, input logic [1:0] cmd, input logic [2:0] src,
                               input logic clr);
      int         exp_lat, exp_acts, lat, acts;
      logic [1:0] exp_op, op;
      logic       exp_err, e;
      logic [2:0] psrc1;
      exp_lat = 1; exp_acts = 0; exp_op = 2'b00; exp_err = 1'b0;
      if (clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      case (cmd)
         2'd1: if (m_depth == DEPTH) begin exp_err = 1; m_ovf = 1; end
               else begin exp_lat = 3; exp_acts = 1; exp_op = 2'b01; m_depth++; m_psrc = src; end
         2'd2: if (m_depth == 0) begin exp_err = 1; m_unf = 1; end
               else begin exp_lat = 2; exp_acts = 1; exp_op = 2'b10; m_depth--; end
         2'd3: if (m_depth == 0) begin exp_err = 1; m_unf = 1; end
               else if (m_depth == DEPTH) begin exp_err = 1; m_ovf = 1; end
               else begin exp_lat = 2; exp_acts = 1; exp_op = 2'b11; m_depth++; end
         default: ;
      endcase

      checks++;
      if (req_if.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s ready: got %b want 1", name, req_if.req_ready);
      end
      run_cmd(cmd, src, clr, lat, acts, op, e, psrc1);

      checks++;
      if (lat !== exp_lat) begin
         failures++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (acts !== exp_acts) begin
         failures++;
         $display("FAIL %s ESAct cycles: got %0d want %0d", name, acts, exp_acts);
      end
      if (exp_acts == 1) begin
         checks++;
         if (op !== exp_op) begin
            failures++;
            $display("FAIL %s ESOp: got %b want %b", name, op, exp_op);
         end
      end
      if (exp_lat == 3) begin
         checks++;
         if (psrc1 !== src) begin
            failures++;
            $display("FAIL %s pushSrc at setup: got %0d want %0d", name, psrc1, src);
         end
      end
      checks++;
      if (e !== exp_err) begin
         failures++;
         $display("FAIL %s err: got %b want %b", name, e, exp_err);
      end
      checks++;
      if (depth !== DW'(m_depth) || full !== (m_depth == DEPTH) || empty !== (m_depth == 0)) begin
         failures++;
         $display("FAIL %s depth/full/empty: got %0d/%b/%b want %0d", name, depth, full, empty, m_depth);
      end
      checks++;
      if (ovf_flag !== m_ovf || unf_flag !== m_unf) begin
         failures++;
         $display("FAIL %s flags ovf/unf: got %b/%b want %b/%b", name, ovf_flag, unf_flag, m_ovf, m_unf);
      end
      checks++;
      if (pushSrc !== m_psrc) begin
         failures++;
         $display("FAIL %s pushSrc held: got %0d want %0d", name, pushSrc, m_psrc);
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (pushSrc !== 3'd0 || ESOp !== 2'b00 || ESAct !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          ovf_flag !== 1'b0 || unf_flag !== 1'b0 || depth !== '0 || empty !== 1'b1 || full !== 1'b0) begin
         failures++;
         $display("FAIL %s reset values: got src=%0d op=%b act=%b done=%b err=%b ovf=%b unf=%b depth=%0d want all zero, empty=1",
                  name, pushSrc, ESOp, ESAct, done, err, ovf_flag, unf_flag, depth);
      end
   endtask

   task automatic pulse_clr_err();
      clr_err = 1'b1;
      @(posedge clk);
      #1 clr_err = 1'b0;
      @(negedge clk);
      m_ovf = 1'b0;
      m_unf = 1'b0;
      checks++;
      if (ovf_flag !== 1'b0 || unf_flag !== 1'b0) begin
         failures++;
         $display("FAIL clr_err flags: got %b/%b want 0/0", ovf_flag, unf_flag);
      end
   endtask

   task automatic test_reset();
      req_if.req_valid = 1'b0;
      req_if.req_cmd   = 2'd0;
      req_if.req_src   = 3'd0;
      reset = 1'b0;
      m_depth = 0; m_ovf = 0; m_unf = 0; m_psrc = 3'd0;
      #12;
      check_reset_values("reset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (req_if.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset ready: got %b want 1", req_if.req_ready);
      end
   endtask

   task automatic test_push_basic();
      test_command("push_src3", 2'd1, 3'd3, 1'b0);
      test_command("nop", 2'd0, 3'd5, 1'b0);
   endtask

   task automatic test_pop_dup();
      test_command("push2", 2'd1, 3'd3, 1'b0);
      test_command("push3", 2'd1, 3'd3, 1'b0);
      test_command("pop", 2'd2, 3'd0, 1'b0);
      test_command("dup", 2'd3, 3'd1, 1'b0);
   endtask

   task automatic test_overflow();
      while (m_depth < DEPTH) test_command("fill", 2'd1, 3'($urandom_range(0, 7)), 1'b0);
      test_command("push_full", 2'd1, 3'd2, 1'b0);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reject pulse width: got done=%b err=%b want 0/0", done, err);
      end
      test_command("dup_full", 2'd3, 3'd0, 1'b0);
      test_command("push_full_clr", 2'd1, 3'd4, 1'b1);
      pulse_clr_err();
   endtask

   task automatic test_underflow();
      while (m_depth > 0) test_command("drain", 2'd2, 3'd0, 1'b0);
      test_command("pop_empty", 2'd2, 3'd0, 1'b0);
      test_command("dup_empty", 2'd3, 3'd0, 1'b0);
      pulse_clr_err();
   endtask

   task automatic test_flush();
      bit got_done;
      while (m_depth < 5) test_command("to5", 2'd1, 3'd1, 1'b0);
      flush = 1'b1;
      req_if.req_valid = 1'b1;
      req_if.req_cmd   = 2'd1;
      req_if.req_src   = 3'd6;
      #1;
      checks++;
      if (req_if.req_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush ready: got %b want 0", req_if.req_ready);
      end
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      m_depth = 0;
      checks++;
      if (depth !== '0 || req_if.req_ready !== 1'b1 || ESAct !== 1'b0) begin
         failures++;
         $display("FAIL flush result: got depth=%0d ready=%b act=%b want 0/1/0", depth, req_if.req_ready, ESAct);
      end
      @(posedge clk);
      #1 req_if.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (req_if.req_ready !== 1'b0 || pushSrc !== 3'd6) begin
         failures++;
         $display("FAIL post-flush accept: got ready=%b src=%0d want 0/6", req_if.req_ready, pushSrc);
      end
      got_done = 0;
      for (int c = 2; c <= 10; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            got_done = 1;
            break;
         end
      end
      m_depth = 1;
      m_psrc  = 3'd6;
      checks++;
      if (!got_done || depth !== DW'(1)) begin
         failures++;
         $display("FAIL post-flush push: got done_seen=%b depth=%0d want 1/1", got_done, depth);
      end
   endtask

   task automatic test_reset_mid();
      req_if.req_valid = 1'b1;
      req_if.req_cmd   = 2'd1;
      req_if.req_src   = 3'd5;
      @(posedge clk);
      #1 req_if.req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (pushSrc !== 3'd5) begin
         failures++;
         $display("FAIL mid-reset setup src: got %0d want 5", pushSrc);
      end
      #1 reset = 1'b0;
      #1;
      check_reset_values("mid_reset");
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (ESAct !== 1'b0) begin
            failures++;
            $display("FAIL mid-reset ESAct: got %b want 0", ESAct);
         end
      end
      reset = 1'b1;
      m_depth = 0; m_ovf = 0; m_unf = 0; m_psrc = 3'd0;
      test_command("push_after_reset", 2'd1, 3'd2, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
            @(negedge clk);
            m_depth = 0;
            checks++;
            if (depth !== '0) begin
               failures++;
               $display("FAIL random flush depth: got %0d want 0", depth);
            end
         end
         // Bias toward pushes so the walk reaches both ends.
         test_command("random", ($urandom_range(0, 9) < 5) ? 2'd1 : 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_push_basic();
      test_pop_dup();
      test_overflow();
      test_underflow();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
